// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply-divide scheduler: opcode encoding,
// controller state encoding and opcode classification helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE = 4'd0;
    localparam logic [3:0] MULT     = 4'd1;
    localparam logic [3:0] MULTU    = 4'd2;
    localparam logic [3:0] DIV      = 4'd3;
    localparam logic [3:0] DIVU     = 4'd4;
    localparam logic [3:0] MTHI     = 4'd5;
    localparam logic [3:0] MTLO     = 4'd6;
    localparam logic [3:0] MFHI     = 4'd7;
    localparam logic [3:0] MFLO     = 4'd8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CORE = 2'd2
    } mdu_state_e;

    // Operations that occupy the iterative arithmetic core.
    function automatic logic is_muldiv(input logic [3:0] op);
        case (op)
            MULT, MULTU, DIV, DIVU: is_muldiv = 1'b1;
            default:                is_muldiv = 1'b0;
        endcase
    endfunction

    // Divide-class operations (divide-by-zero leaves HI/LO untouched).
    function automatic logic is_div(input logic [3:0] op);
        case (op)
            DIV, DIVU: is_div = 1'b1;
            default:   is_div = 1'b0;
        endcase
    endfunction

    // Architectural busy latency of an operation, zero for non-core ops.
    function automatic logic [31:0] op_latency(input logic [3:0]  op,
                                               input logic [31:0] mult_cycles,
                                               input logic [31:0] div_cycles);
        case (op)
            MULT, MULTU: op_latency = mult_cycles;
            DIV, DIVU:   op_latency = div_cycles;
            default:     op_latency = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module mdu_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Counter register: load has priority over decrement; holds at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/mdu_sched_chk.sv
// Protocol checker for the multiply-divide scheduler: no MDU operation may
// be presented in E while an operation is still in flight.
module mdu_sched_chk
    import mdu_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input logic       busy,
    input logic [3:0] e_op
);

    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(busy && (e_op != MDU_NONE))
    ) else $error("mdu_sched: MDU op %0d presented while busy", e_op);

endmodule

// File: rtl/mdu_sched.sv
// Multiply-divide scheduler: issues operations to an external iterative
// core, enforces the architectural latency, owns HI/LO and raises the
// D-stage MDU stall request.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_src_a,
    input  logic [31:0] e_src_b,
    input  logic        d_md,
    input  logic        d_mf,
    input  logic        d_mt,
    output logic        core_req,
    output logic [3:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_done,
    input  logic [31:0] core_hi,
    input  logic [31:0] core_lo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    mdu_state_e  state_r, state_s;
    logic        busy_r, busy_s;
    logic        core_req_r, core_req_s;
    logic [3:0]  core_op_r, core_op_s;
    logic [31:0] core_a_r, core_a_s;
    logic [31:0] core_b_r, core_b_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic        done_seen_r, done_seen_s;
    logic [31:0] res_hi_r, res_hi_s;
    logic [31:0] res_lo_r, res_lo_s;

    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_zero_s;
    logic [31:0]      lat_s;
    logic [31:0]      commit_hi_s;
    logic [31:0]      commit_lo_s;
    logic             div0_s;

    mdu_lat_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    assign lat_s       = op_latency(e_op, 32'(MULT_CYCLES), 32'(DIV_CYCLES));
    // A result arriving in the commit cycle itself bypasses the capture regs.
    assign commit_hi_s = core_done ? core_hi : res_hi_r;
    assign commit_lo_s = core_done ? core_lo : res_lo_r;
    assign div0_s      = is_div(core_op_r) && (core_b_r == 32'd0);

    // Next-state and datapath update for the issue/run/wait controller.
    always_comb begin
        state_s     = state_r;
        busy_s      = busy_r;
        core_req_s  = 1'b0;
        core_op_s   = core_op_r;
        core_a_s    = core_a_r;
        core_b_s    = core_b_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        done_seen_s = done_seen_r;
        res_hi_s    = res_hi_r;
        res_lo_s    = res_lo_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_val_s   = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (is_muldiv(e_op)) begin
                    core_op_s   = e_op;
                    core_a_s    = e_src_a;
                    core_b_s    = e_src_b;
                    core_req_s  = 1'b1;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = CNT_W'(lat_s - 32'd1);
                    done_seen_s = 1'b0;
                    busy_s      = 1'b1;
                    state_s     = RUN;
                end else if (e_op == MTHI) begin
                    hi_s = e_src_a;
                end else if (e_op == MTLO) begin
                    lo_s = e_src_a;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                cnt_dec_s = 1'b1;
                if (core_done) begin
                    done_seen_s = 1'b1;
                    res_hi_s    = core_hi;
                    res_lo_s    = core_lo;
                end else begin
                    done_seen_s = done_seen_r;
                end
                if (cnt_zero_s) begin
                    if (done_seen_r || core_done) begin
                        if (!div0_s) begin
                            hi_s = commit_hi_s;
                            lo_s = commit_lo_s;
                        end else begin
                            hi_s = hi_r;
                            lo_s = lo_r;
                        end
                        busy_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_CORE;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            WAIT_CORE: begin
                if (core_done) begin
                    res_hi_s    = core_hi;
                    res_lo_s    = core_lo;
                    done_seen_s = 1'b1;
                    if (!div0_s) begin
                        hi_s = commit_hi_s;
                        lo_s = commit_lo_s;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_CORE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Controller, core interface and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            core_req_r  <= 1'b0;
            core_op_r   <= MDU_NONE;
            core_a_r    <= 32'd0;
            core_b_r    <= 32'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            done_seen_r <= 1'b0;
            res_hi_r    <= 32'd0;
            res_lo_r    <= 32'd0;
        end else begin
            state_r     <= state_s;
            busy_r      <= busy_s;
            core_req_r  <= core_req_s;
            core_op_r   <= core_op_s;
            core_a_r    <= core_a_s;
            core_b_r    <= core_b_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            done_seen_r <= done_seen_s;
            res_hi_r    <= res_hi_s;
            res_lo_r    <= res_lo_s;
        end
    end

    assign busy     = busy_r;
    assign core_req = core_req_r;
    assign core_op  = core_op_r;
    assign core_a   = core_a_r;
    assign core_b   = core_b_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    // Stall must react in the issue cycle, so it is decoded from live E/D state.
    assign stall    = (is_muldiv(e_op) & ~busy_r) | (busy_r & (d_md | d_mf | d_mt));

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: stimulus pushes the expected busy length
// and HI/LO for each operation; a monitor pops and checks at each busy fall.
module tb_mdu_sched;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_src_a;
    logic [31:0] e_src_b;
    logic        d_md;
    logic        d_mf;
    logic        d_mt;
    logic        core_req;
    logic [3:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    typedef struct {
        int          blen;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_op      (e_op),
        .e_src_a   (e_src_a),
        .e_src_b   (e_src_b),
        .d_md      (d_md),
        .d_mf      (d_mf),
        .d_mt      (d_mt),
        .core_req  (core_req),
        .core_op   (core_op),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_done (core_done),
        .core_hi   (core_hi),
        .core_lo   (core_lo),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall     (stall)
    );

    mdu_sched_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .busy  (busy),
        .e_op  (e_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one core operation, act as the core (done pulse on done_cyc),
    // and optionally hold mflo in D to check stall each busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int done_cyc, input logic [31:0] dh, input logic [31:0] dl,
                          input int blen, input logic [31:0] eh, input logic [31:0] el,
                          input logic mf);
        exp_t e;
        e.blen = blen;
        e.hi   = eh;
        e.lo   = el;
        q.push_back(e);
        e_op    = op;
        e_src_a = a;
        e_src_b = b;
        d_mf    = mf;
        #1;
        chk("stall_issue", 32'(stall), 32'd1);
        tick();
        e_op = MDU_NONE;
        for (int cyc = 1; cyc <= blen + 1; cyc++) begin
            if (cyc == 1) begin
                chk("core_req_pulse", 32'(core_req), 32'd1);
                chk("core_op", 32'(core_op), 32'(op));
                chk("core_a", core_a, a);
                chk("core_b", core_b, b);
            end
            if (cyc == 2) chk("core_req_single", 32'(core_req), 32'd0);
            core_done = (cyc == done_cyc);
            core_hi   = dh;
            core_lo   = dl;
            if (mf) begin
                #1;
                chk("stall_busy", 32'(stall), (cyc <= blen) ? 32'd1 : 32'd0);
            end
            if (cyc <= blen) tick();
        end
        core_done = 1'b0;
        d_mf      = 1'b0;
    endtask

    // Monitor: measure each busy period and check it against the scoreboard.
    initial begin
        int   bcnt = 0;
        logic bprev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bcnt++;
            end else begin
                if (bprev) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL commit_unexpected: busy fell with nothing expected");
                    end else begin
                        e = q.pop_front();
                        chk("commit_busy_len", 32'(bcnt), 32'(e.blen));
                        chk("commit_hi", hi, e.hi);
                        chk("commit_lo", lo, e.lo);
                    end
                end
                bcnt = 0;
            end
            bprev = (busy === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1; e_op = MDU_NONE; e_src_a = 32'd0; e_src_b = 32'd0;
        d_md = 1'b0; d_mf = 1'b0; d_mt = 1'b0;
        core_done = 1'b0; core_hi = 32'd0; core_lo = 32'd0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_req", 32'(core_req), 32'd0);
        chk("rst_core_op", 32'(core_op), 32'(MDU_NONE));
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_core_b", core_b, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        // MULT 3 * -2, prompt core on cycle 3
        run_op(MULT, 32'd3, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);

        // stray core_done while idle must be ignored
        core_done = 1'b1; core_hi = 32'hCAFE_0001; core_lo = 32'hCAFE_0002;
        tick();
        core_done = 1'b0;
        tick();
        chk("idle_done_hi", hi, 32'hFFFF_FFFF);
        chk("idle_done_lo", lo, 32'hFFFF_FFFA);
        chk("idle_done_busy", 32'(busy), 32'd0);

        // DIVU 17 / 5, late core forces WAIT_CORE
        run_op(DIVU, 32'd17, 32'd5, 12, 32'd2, 32'd3, 12, 32'd2, 32'd3, 1'b0);

        // MTHI while idle, MFHI in D
        e_op = MTHI; e_src_a = 32'h1234_5678;
        #1;
        chk("mthi_stall_e", 32'(stall), 32'd0);
        tick();
        e_op = MDU_NONE; d_mf = 1'b1;
        #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_kept", lo, 32'd3);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_stall_d", 32'(stall), 32'd0);
        d_mf = 1'b0;
        tick();

        // DIV by zero preserves HI/LO
        e_op = MTHI; e_src_a = 32'hA;
        tick();
        e_op = MTLO; e_src_a = 32'hB;
        tick();
        e_op = MDU_NONE;
        chk("mt_hi", hi, 32'hA);
        chk("mt_lo", lo, 32'hB);
        run_op(DIV, 32'd7, 32'd0, 4, 32'hDEAD_DEAD, 32'hBEEF_BEEF, 10, 32'hA, 32'hB, 1'b0);

        // MULT 6 * 7 with mflo in D every cycle; done on the final count cycle
        run_op(MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42, 5, 32'd0, 32'd42, 1'b1);

        // reset in the 3rd busy cycle of a DIV aborts it
        e.blen = 3; e.hi = 32'd0; e.lo = 32'd0;
        q.push_back(e);
        e_op = DIV; e_src_a = 32'd100; e_src_b = 32'd7;
        tick();
        e_op = MDU_NONE;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        core_done = 1'b1; core_hi = 32'h55; core_lo = 32'h55;
        tick();
        core_done = 1'b0;
        tick();
        chk("late_done_hi", hi, 32'd0);
        chk("late_done_lo", lo, 32'd0);
        chk("late_done_busy", 32'(busy), 32'd0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
